regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side driver for the 32x64-bit register file's single write port. It accepts results from the single-cycle ALU path and the variable-latency memory/load path through valid/ready handshakes, and buffers them in a small in-order FIFO. It drives one registered write (`RegWrite`/`rd`/`WriteData`) per cycle, in the order results were accepted. Writes to x0 are filtered here so the register file never sees them.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, excluding the output register; power of two, ≥2.
- `XLEN`, 64: data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `alu_valid` in 1: ALU result offered.
- `alu_rd` in 5: destination of the ALU result.
- `alu_data` in XLEN: ALU result data.
- `alu_ready` out 1: ALU result accepted this cycle when high with `alu_valid`.
- `mem_valid` in 1: load result offered.
- `mem_rd` in 5: destination of the load result.
- `mem_data` in XLEN: load result data.
- `mem_ready` out 1: load result accepted this cycle when high with `mem_valid`.
- `wb_stall` in 1: freezes draining; no write is issued on the next edge.
- `RegWrite` out 1: register file write enable.
- `rd` out 5: register file write address.
- `WriteData` out XLEN: register file write data.
- `count` out log2(DEPTH)+1: FIFO occupancy.
- `fwd_rs1`, `fwd_rs2` in 5: forwarding lookup addresses (only with `WB_FWD_EN`).
- `fwd_hit1`, `fwd_hit2` out 1, `fwd_data1`, `fwd_data2` out XLEN: forwarding results (only with `WB_FWD_EN`).

## Operation
- Take signals:
  - `alu_take = alu_valid & alu_ready`.
  - `mem_take = mem_valid & mem_ready`.
  - A take with rd==0 completes its handshake but is discarded: no enqueue, no write.
- Sources are ordered oldest-first as FIFO head, then ALU, then memory. An ALU and a memory result taken in the same cycle are ordered ALU before memory.
- Drain: `drain = !wb_stall`. On each edge where drain=1 and at least one entry (FIFO or a non-x0 take) is available, the oldest entry is loaded into the output register with `RegWrite`=1. All other kept entries are enqueued in order.
- When nothing is loaded on an edge (stall, or nothing available), the next cycle has `RegWrite`=0 and `rd`/`WriteData` hold their previous values.
- Ready rules (combinational from registered `count`):
  - `alu_ready = (count < DEPTH) | drain`.
  - `mem_ready = (count + k < DEPTH + drain)`, where k=1 if the ALU take is non-x0, else 0.
- Occupancy update: `count_next = count + kept_takes - loaded_from_fifo_or_takes_into_FIFO_path`. It never exceeds DEPTH. Pointers wrap modulo DEPTH.

## Timing
- Reset (asserted low, asynchronous): `RegWrite`=0, `rd`=0, `WriteData`=0, `count`=0, FIFO pointers at 0. Consequently `alu_ready`=1 and `mem_ready`=1.
- Reset mid-operation discards all buffered entries and any write in flight. There is no partial write after release.
- Latency: a result taken with an empty FIFO and drain=1 appears on the write port the cycle after the take (one edge).
- Full with stall: at `count`=DEPTH and `wb_stall`=1, both readys are 0.
- Full without stall: at `count`=DEPTH and `wb_stall`=0, the ALU is accepted (the head drains). The memory source is accepted only if the ALU does not take a non-x0 result.
- Empty with both sources valid: the ALU result goes out first; the memory result enqueues (`count`=1).
- The write port is registered, so the register file samples a stable `RegWrite`/`rd`/`WriteData` for the whole cycle.

## Configuration
- `WB_FWD_EN` defined: combinational forwarding lookups are present.
  - `fwd_hitN`=1 when `fwd_rsN`≠0 matches any FIFO entry or the output register while `RegWrite`=1.
  - `fwd_dataN` is the newest match, searched newest FIFO entry first, then older entries, then the output register.
  - On no match, `fwd_hitN`=0 and `fwd_dataN`=0.
- `WB_FWD_EN` undefined: the forwarding ports are absent and no comparator logic is built.

## Test plan
- Reset, then single write: take alu rd=5, data=0x1234 with FIFO empty → next cycle `RegWrite`=1, `rd`=5, `WriteData`=0x1234; the following cycle `RegWrite`=0.
- Simultaneous take: alu(rd=3, 0xA) and mem(rd=4, 0xB) in the same cycle → consecutive writes x3=0xA then x4=0xB; `count` goes 1 then 0.
- x0 filter: alu rd=0, data=0xFF with ready=1 → handshake completes, no `RegWrite` pulse, `count` stays 0.
- Full and stall: hold `wb_stall`=1 and fill with 4 ALU entries (plus 1 in the output register) → `count`=4, both readys 0. Release the stall → entries drain in order, one per cycle, with no loss.
- Reset mid-drain: `count`=3, pull `reset` low asynchronously between edges → `RegWrite`=0 and `count`=0 immediately; after release, no stale writes appear.
- With `WB_FWD_EN` defined: FIFO holds x7=1 then x7=2, `fwd_rs1`=7 → `fwd_hit1`=1, `fwd_data1`=2. With `fwd_rs1`=0 → `fwd_hit1`=0.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order ALU/load result buffer driving the register file write port, x0 writes dropped.
// Define WB_FWD_EN to add combinational forwarding lookups over buffered and in-flight writes.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [4:0]              mem_rd,
    input  logic [XLEN-1:0]         mem_data,
    output logic                    mem_ready,
    input  logic                    wb_stall,
    output logic                    RegWrite,
    output logic [4:0]              rd,
    output logic [XLEN-1:0]         WriteData,
    output logic [$clog2(DEPTH):0]  count
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]              fwd_rs1,
    input  logic [4:0]              fwd_rs2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [XLEN-1:0]         fwd_data1,
    output logic [XLEN-1:0]         fwd_data2
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [AW-1:0]   wptr, rptr;

    logic            drain, alu_keep, mem_keep, has, load, pop, skip;
    logic [1:0]      npush;
    logic [4:0]      e0_rd, p0_rd, out_rd;
    logic [XLEN-1:0] e0_data, p0_data, out_data;

    // A take that is loaded straight to the output (skip) is removed from the enqueue list.
    always_comb begin
        drain     = !wb_stall;
        alu_ready = (count < FULL) | drain;
        alu_keep  = alu_valid & alu_ready & (alu_rd != 5'd0);
        mem_ready = ({1'b0, count} + (CW+1)'(alu_keep)) < ({1'b0, FULL} + (CW+1)'(drain));
        mem_keep  = mem_valid & mem_ready & (mem_rd != 5'd0);
        has       = count != '0;
        load      = drain & (has | alu_keep | mem_keep);
        pop       = load & has;
        skip      = load & !has;
        npush     = {1'b0, alu_keep} + {1'b0, mem_keep} - {1'b0, skip};
        e0_rd     = alu_keep ? alu_rd : mem_rd;
        e0_data   = alu_keep ? alu_data : mem_data;
        p0_rd     = skip ? mem_rd : e0_rd;
        p0_data   = skip ? mem_data : e0_data;
        out_rd    = has ? q_rd[rptr] : e0_rd;
        out_data  = has ? q_data[rptr] : e0_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite  <= 1'b0;
            rd        <= '0;
            WriteData <= '0;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            RegWrite <= load;
            if (load) begin
                rd        <= out_rd;
                WriteData <= out_data;
            end
            if (pop) rptr <= rptr + AW'(1);
            wptr  <= wptr + AW'(npush);
            count <= count + CW'(npush) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (npush != 2'd0) begin
            q_rd[wptr]   <= p0_rd;
            q_data[wptr] <= p0_data;
        end
        if (npush == 2'd2) begin
            q_rd[wptr + AW'(1)]   <= mem_rd;
            q_data[wptr + AW'(1)] <= mem_data;
        end
    end

`ifdef WB_FWD_EN
    // Walk oldest to newest so the newest match wins; the output register is the oldest.
    function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
        logic [XLEN:0] r;
        r = (RegWrite && rd == rs && rs != 5'd0) ? {1'b1, WriteData} : '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count && q_rd[rptr + AW'(i)] == rs && rs != 5'd0)
                r = {1'b1, q_data[rptr + AW'(i)]};
        return r;
    endfunction

    always_comb begin
        {fwd_hit1, fwd_data1} = lookup(fwd_rs1);
        {fwd_hit2, fwd_data2} = lookup(fwd_rs2);
    end
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed stimulus with an expected-write queue checked by a write-port monitor.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, wb_stall;
    logic [4:0]  alu_rd, mem_rd, rd;
    logic [63:0] alu_data, mem_data, WriteData;
    logic        alu_ready, mem_ready, RegWrite;
    logic [2:0]  count;
    logic [4:0]  fwd_rs1, fwd_rs2;
    logic        fwd_hit1, fwd_hit2;
    logic [63:0] fwd_data1, fwd_data2;

    regfile_writeback #(.DEPTH(4), .XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_stall(wb_stall), .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData), .count(count)
`ifdef WB_FWD_EN
        , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } wr_t;
    wr_t exp_q[$];
    int  total = 0;
    int  passed = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [63:0] d);
        wr_t w;
        w.rd = r;
        w.d  = d;
        exp_q.push_back(w);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] r, input logic [63:0] d);
        alu_valid = v;
        alu_rd    = r;
        alu_data  = d;
    endtask

    task automatic mem(input logic v, input logic [4:0] r, input logic [63:0] d);
        mem_valid = v;
        mem_rd    = r;
        mem_data  = d;
    endtask

    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_write: unexpected write rd=%0d data=%0h", rd, WriteData);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if (rd === w.rd && WriteData === w.d) passed++;
                else $display("FAIL wb_write: got rd=%0d data=%0h, expected rd=%0d data=%0h",
                              rd, WriteData, w.rd, w.d);
            end
        end
    end

    initial begin
        reset = 1'b0;
        wb_stall = 1'b0;
        fwd_rs1 = '0;
        fwd_rs2 = '0;
        alu(0, 0, 0);
        mem(0, 0, 0);
        cyc();
        cyc();
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_count", count, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 1);
        reset = 1'b1;
        cyc();

        // single write, one-edge latency
        alu(1, 5, 64'h1234);
        expect_wr(5, 64'h1234);
        #1 chk("single_alu_ready", alu_ready, 1);
        cyc();
        alu(0, 0, 0);
        chk("single_count", count, 0);
        cyc();
        chk("single_off", RegWrite, 0);

        // simultaneous ALU + mem: ALU first
        alu(1, 3, 64'hA);
        mem(1, 4, 64'hB);
        expect_wr(3, 64'hA);
        expect_wr(4, 64'hB);
        #1 chk("sim_mem_ready", mem_ready, 1);
        cyc();
        alu(0, 0, 0);
        mem(0, 0, 0);
        chk("sim_count1", count, 1);
        cyc();
        chk("sim_count0", count, 0);
        cyc();

        // x0 filter
        alu(1, 0, 64'hFF);
        #1 chk("x0_ready", alu_ready, 1);
        cyc();
        alu(0, 0, 0);
        chk("x0_count", count, 0);
        cyc();
        chk("x0_no_write", RegWrite, 0);

        // full and stall, then full without stall
        alu(1, 10, 64'h100);
        expect_wr(10, 64'h100);
        cyc();
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu(1, 5'(11 + i), 64'h110 + 64'(i));
            expect_wr(5'(11 + i), 64'h110 + 64'(i));
            #1 chk("fill_ready", alu_ready, 1);
            cyc();
        end
        chk("full_count", count, 4);
        alu(1, 15, 64'h150);
        mem(1, 17, 64'h170);
        #1;
        chk("full_stall_alu_ready", alu_ready, 0);
        chk("full_stall_mem_ready", mem_ready, 0);
        wb_stall = 1'b0;
        alu(1, 16, 64'h160);
        #1;
        chk("full_drain_alu_ready", alu_ready, 1);
        chk("full_drain_mem_ready", mem_ready, 0);
        expect_wr(16, 64'h160);
        cyc();
        alu(0, 0, 0);
        mem(0, 0, 0);
        chk("full_drain_count", count, 4);
        repeat (5) cyc();
        chk("drained_count", count, 0);

        // reset mid-drain discards everything
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu(1, 5'(20 + i), 64'h200 + 64'(i));
            cyc();
        end
        alu(0, 0, 0);
        expect_wr(20, 64'h200);
        wb_stall = 1'b0;
        cyc();
        chk("pre_reset_count", count, 3);
        #6 reset = 1'b0;
        #1;
        chk("mid_reset_regwrite", RegWrite, 0);
        chk("mid_reset_count", count, 0);
        cyc();
        cyc();
        reset = 1'b1;
        repeat (6) cyc();
        chk("post_reset_count", count, 0);

`ifdef WB_FWD_EN
        wb_stall = 1'b1;
        alu(1, 7, 64'd1);
        cyc();
        alu(1, 7, 64'd2);
        cyc();
        alu(0, 0, 0);
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd9;
        #1;
        chk("fwd_hit1", fwd_hit1, 1);
        chk("fwd_data1", fwd_data1, 64'd2);
        chk("fwd_miss_hit2", fwd_hit2, 0);
        chk("fwd_miss_data2", fwd_data2, 0);
        fwd_rs1 = 5'd0;
        #1;
        chk("fwd_x0_hit1", fwd_hit1, 0);
        expect_wr(7, 64'd1);
        expect_wr(7, 64'd2);
        wb_stall = 1'b0;
        repeat (4) cyc();
`endif

        repeat (3) cyc();
        chk("exp_queue_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
